axi_rr_arb_mux: RTL and testbench

- N-to-1 round-robin arbitrating multiplexer for valid/ready packet streams.
- Sits directly upstream of axi_skidbuffer on each interconnect channel, for example AW or W merging from several masters.
- Grants one source at a time and holds the grant until that source's last beat is accepted.
- Drives a forward-registered output stream (m_valid, m_data, m_last, m_id) into the skid buffer.

---
 rtl/axi_rr_arb_mux.sv | 99 +++++++++
 tb/tb_axi_rr_arb_mux.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rr_arb_mux.sv
// rtl/axi_rr_arb_mux.sv - N-to-1 round-robin packet arbiter with a forward-registered output.
// Grant is held from a packet's first accepted beat until its last beat is accepted.
module axi_rr_arb_mux #(
  parameter int NS = 4,
  parameter int DW = 8,
  parameter int IW = $clog2(NS)
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic [NS-1:0]    s_valid,
  output logic [NS-1:0]    s_ready,
  input  logic [NS*DW-1:0] s_data,
  input  logic [NS-1:0]    s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DW-1:0]    m_data,
  output logic             m_last,
  output logic [IW-1:0]    m_id
);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t          state;
  logic [IW-1:0]   grant;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   idle_sel;
  logic [IW-1:0]   sel;
  logic [IW-1:0]   idx;
  logic            found;
  logic            load_en;
  logic            accept;
  logic [DW-1:0]   sel_data;
  logic            sel_last;

  // Search starts just past the last packet's source, so that source ends up lowest priority.
  always_comb begin
    found    = 1'b0;
    idle_sel = '0;
    idx      = '0;
    for (int k = 1; k <= NS; k++) begin
      idx = IW'((int'(rr_ptr) + k) % NS);
      if (!found && s_valid[idx]) begin
        found    = 1'b1;
        idle_sel = idx;
      end
    end
  end

  assign sel     = (state == LOCKED) ? grant : idle_sel;
  assign load_en = ~m_valid | m_ready;

  always_comb begin
    s_ready = '0;
    if (i_resetn && load_en && (state == LOCKED || |s_valid))
      s_ready[sel] = 1'b1;
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NS; i++) begin
      if (sel == IW'(i))
        sel_data = s_data[i*DW +: DW];
    end
  end

  assign sel_last = s_last[sel];
  assign accept   = s_valid[sel] & s_ready[sel];

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
      m_id    <= '0;
      state   <= IDLE;
      grant   <= '0;
      rr_ptr  <= IW'(NS - 1);
    end else if (accept) begin
      m_valid <= 1'b1;
      m_data  <= sel_data;
      m_last  <= sel_last;
      m_id    <= sel;
      if (state == IDLE) begin
        if (sel_last) begin
          rr_ptr <= sel;
        end else begin
          state <= LOCKED;
          grant <= sel;
        end
      end else if (sel_last) begin
        state  <= IDLE;
        rr_ptr <= grant;
      end
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_rr_arb_mux.sv
// tb/tb_axi_rr_arb_mux.sv - directed testbench for axi_rr_arb_mux (NS=4, DW=8).
module tb_axi_rr_arb_mux;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  s_valid = '0;
  logic [3:0]  s_ready;
  logic [31:0] s_data = '0;
  logic [3:0]  s_last = '0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [7:0]  m_data;
  logic        m_last;
  logic [1:0]  m_id;

  int tests = 0;
  int fails = 0;

  axi_rr_arb_mux #(.NS(4), .DW(8), .IW(2)) dut (
    .i_clk    (clk),
    .i_resetn (resetn),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last),
    .m_id     (m_id)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    s_valid = 4'b0110;
    m_ready = 1'b1;
    tick();
    tick();
    tests++;
    if ({m_valid, m_last, m_id, m_data} !== 12'h000) begin
      fails++;
      $display("FAIL reset_outputs got=%h exp=000", {m_valid, m_last, m_id, m_data});
    end
    tests++;
    if (s_ready !== 4'b0000) begin
      fails++;
      $display("FAIL reset_s_ready got=%b exp=0000", s_ready);
    end
    s_valid = '0;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    tests++;
    if (s_ready !== 4'b0000) begin
      fails++;
      $display("FAIL reset_idle_ready got=%b exp=0000", s_ready);
    end
  endtask

  task automatic test_single();
    logic [7:0] v [3];
    v[0] = 8'hA1; v[1] = 8'hA2; v[2] = 8'hA3;
    for (int i = 0; i < 3; i++) begin
      s_valid = 4'b0100;
      s_data = '0;
      s_data[23:16] = v[i];
      s_last = (i == 2) ? 4'b0100 : 4'b0000;
      m_ready = 1'b1;
      #1;
      tests++;
      if (s_ready !== 4'b0100) begin
        fails++;
        $display("FAIL single_ready beat=%0d got=%b exp=0100", i, s_ready);
      end
      tick();
      tests++;
      if ({m_valid, m_last, m_id, m_data} !== {1'b1, (i == 2), 2'd2, v[i]}) begin
        fails++;
        $display("FAIL single_out beat=%0d got=%h exp=%h", i, {m_valid, m_last, m_id, m_data},
                 {1'b1, (i == 2), 2'd2, v[i]});
      end
    end
    s_valid = '0;
    s_last = '0;
    #1;
    tests++;
    if (s_ready !== 4'b0000) begin
      fails++;
      $display("FAIL single_back_to_idle got=%b exp=0000", s_ready);
    end
    tick();
    tests++;
    if (m_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_drain got=%b exp=0", m_valid);
    end
  endtask

  task automatic test_round_robin();
    int bidx [4];
    int exp_src;
    logic [7:0] exp_data;
    for (int s = 0; s < 4; s++) bidx[s] = 0;
    #2 resetn = 1'b0;
    #2 resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_valid = 4'hF;
      for (int s = 0; s < 4; s++) begin
        s_data[s*8 +: 8] = {4'(s), 4'(bidx[s])};
        s_last[s] = bidx[s][0];
      end
      m_ready = 1'b1;
      #1;
      exp_src = (i / 2) % 4;
      tests++;
      if (s_ready !== 4'(1 << exp_src)) begin
        fails++;
        $display("FAIL rr_ready beat=%0d got=%b exp=%b", i, s_ready, 4'(1 << exp_src));
      end
      tick();
      exp_data = {4'(exp_src), 4'((i / 8) * 2 + i % 2)};
      tests++;
      if ({m_valid, m_last, m_id, m_data} !== {1'b1, 1'(i % 2), 2'(exp_src), exp_data}) begin
        fails++;
        $display("FAIL rr_out beat=%0d got=%h exp=%h", i, {m_valid, m_last, m_id, m_data},
                 {1'b1, 1'(i % 2), 2'(exp_src), exp_data});
      end
      bidx[exp_src]++;
    end
    s_valid = '0;
    s_last = '0;
    tick();
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int recv = 0;
    logic acc, fire, hold;
    logic [10:0] snap;
    logic [3:0] exp_ready;
    for (int c = 0; c < 80 && recv < 4; c++) begin
      s_valid = (sent < 4) ? 4'b0010 : 4'b0000;
      s_data = '0;
      s_data[15:8] = 8'(8'hB0 + sent);
      s_last = (sent == 3) ? 4'b0010 : 4'b0000;
      m_ready = (c >= 40) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      exp_ready = ((!m_valid || m_ready) && sent < 4) ? 4'b0010 : 4'b0000;
      tests++;
      if (s_ready !== exp_ready) begin
        fails++;
        $display("FAIL bp_ready cycle=%0d got=%b exp=%b", c, s_ready, exp_ready);
      end
      acc = s_valid[1] & s_ready[1];
      fire = m_valid & m_ready;
      hold = m_valid & ~m_ready;
      snap = {m_last, m_id, m_data};
      tick();
      if (acc) sent++;
      if (fire) begin
        tests++;
        if (snap !== {(recv == 3), 2'd1, 8'(8'hB0 + recv)}) begin
          fails++;
          $display("FAIL bp_data idx=%0d got=%h exp=%h", recv, snap, {(recv == 3), 2'd1, 8'(8'hB0 + recv)});
        end
        recv++;
      end
      if (hold) begin
        tests++;
        if ({m_valid, m_last, m_id, m_data} !== {1'b1, snap}) begin
          fails++;
          $display("FAIL bp_stable cycle=%0d got=%h exp=%h", c, {m_valid, m_last, m_id, m_data}, {1'b1, snap});
        end
      end
    end
    tests++;
    if (recv !== 4) begin
      fails++;
      $display("FAIL bp_count got=%0d exp=4", recv);
    end
    s_valid = '0;
    s_last = '0;
    m_ready = 1'b1;
    tick();
  endtask

  task automatic test_lock();
    logic [3:0] exp_ready;
    logic [7:0] exp_data;
    for (int c = 0; c < 6; c++) begin
      s_valid = {(c >= 2), 2'b00, 1'b1};
      s_data = '0;
      s_data[7:0] = (c < 4) ? 8'(c) : 8'h04;
      s_data[31:24] = (c < 5) ? 8'h30 : 8'h31;
      s_last = {(c == 5), 2'b00, (c == 3)};
      m_ready = 1'b1;
      #1;
      exp_ready = (c < 4) ? 4'b0001 : 4'b1000;
      tests++;
      if (s_ready !== exp_ready) begin
        fails++;
        $display("FAIL lock_ready cycle=%0d got=%b exp=%b", c, s_ready, exp_ready);
      end
      tick();
      exp_data = (c < 4) ? 8'(c) : 8'(8'h30 + c - 4);
      tests++;
      if ({m_valid, m_last, m_id, m_data} !== {1'b1, (c == 3 || c == 5), (c < 4) ? 2'd0 : 2'd3, exp_data}) begin
        fails++;
        $display("FAIL lock_out cycle=%0d got=%h exp=%h", c, {m_valid, m_last, m_id, m_data},
                 {1'b1, (c == 3 || c == 5), (c < 4) ? 2'd0 : 2'd3, exp_data});
      end
    end
    s_valid = '0;
    s_last = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    int exp_src;
    for (int i = 0; i < 6; i++) begin
      s_valid = 4'b0110;
      s_last = 4'b0110;
      s_data = {8'h00, 8'h22, 8'h11, 8'h00};
      m_ready = 1'b1;
      #1;
      exp_src = (i % 2 == 0) ? 1 : 2;
      tests++;
      if (s_ready !== 4'(1 << exp_src)) begin
        fails++;
        $display("FAIL b2b_ready beat=%0d got=%b exp=%b", i, s_ready, 4'(1 << exp_src));
      end
      tick();
      tests++;
      if ({m_valid, m_last, m_id, m_data} !== {2'b11, 2'(exp_src), (exp_src == 1) ? 8'h11 : 8'h22}) begin
        fails++;
        $display("FAIL b2b_out beat=%0d got=%h exp=%h", i, {m_valid, m_last, m_id, m_data},
                 {2'b11, 2'(exp_src), (exp_src == 1) ? 8'h11 : 8'h22});
      end
    end
    s_valid = '0;
    s_last = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 2; c++) begin
      s_valid = 4'b0010;
      s_data = '0;
      s_data[15:8] = 8'(8'hC0 + c);
      s_last = '0;
      m_ready = 1'b1;
      tick();
      tests++;
      if ({m_valid, m_last, m_id, m_data} !== {2'b10, 2'd1, 8'(8'hC0 + c)}) begin
        fails++;
        $display("FAIL rstmid_out beat=%0d got=%h exp=%h", c, {m_valid, m_last, m_id, m_data},
                 {2'b10, 2'd1, 8'(8'hC0 + c)});
      end
    end
    s_data[15:8] = 8'hC2;
    #2 resetn = 1'b0;
    #1;
    tests++;
    if ({m_valid, m_last, m_id, m_data} !== 12'h000) begin
      fails++;
      $display("FAIL rstmid_async got=%h exp=000", {m_valid, m_last, m_id, m_data});
    end
    tests++;
    if (s_ready !== 4'b0000) begin
      fails++;
      $display("FAIL rstmid_ready got=%b exp=0000", s_ready);
    end
    @(negedge clk);
    resetn = 1'b1;
    s_valid = 4'b1010;
    s_last = 4'b1010;
    s_data = {8'h3A, 8'h00, 8'h1A, 8'h00};
    #1;
    tests++;
    if (s_ready !== 4'b0010) begin
      fails++;
      $display("FAIL rstmid_first_ready got=%b exp=0010", s_ready);
    end
    tick();
    tests++;
    if ({m_valid, m_last, m_id, m_data} !== {2'b11, 2'd1, 8'h1A}) begin
      fails++;
      $display("FAIL rstmid_first_out got=%h exp=%h", {m_valid, m_last, m_id, m_data}, {2'b11, 2'd1, 8'h1A});
    end
    s_valid = '0;
    s_last = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_lock();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
